// File: rtl/logic_unit_pkg.sv
// Shared types and gate functions for the registered logic unit.
// Functions work on LU_MAX_W-bit words; callers pad narrower operands.
package logic_unit_pkg;

    localparam int LU_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        MODE_BITWISE  = 2'd0,
        MODE_REDUCE   = 2'd1,
        MODE_FOLD     = 2'd2,
        MODE_RESERVED = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FOLD = 1'b1
    } fsm_e;

    function automatic logic [LU_MAX_W-1:0] apply_op(input op_e op,
                                                     input logic [LU_MAX_W-1:0] x,
                                                     input logic [LU_MAX_W-1:0] y);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_NOR:  return ~(x | y);
            OP_NAND: return ~(x & y);
            OP_XOR:  return x ^ y;
            OP_XNOR: return ~(x ^ y);
            OP_NOT:  return ~x;
            default: return x;
        endcase
    endfunction

    // AND-type reductions expect unused upper bits padded with ones, the rest with zeros.
    function automatic logic reduce_op(input op_e op, input logic [LU_MAX_W-1:0] x);
        case (op)
            OP_AND:  return &x;
            OP_OR:   return |x;
            OP_NOR:  return ~|x;
            OP_NAND: return ~&x;
            OP_XOR:  return ^x;
            OP_XNOR: return ~^x;
            OP_NOT:  return ~x[0];
            default: return x[0];
        endcase
    endfunction

endpackage

// File: rtl/logic_unit_seq_core.sv
// Combinational gate core: bitwise result and reduction bit of one operand pair.
// WIDTH must not exceed LU_MAX_W.
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res,
    output logic             red
);

    logic [LU_MAX_W-1:0] x_ext;
    logic [LU_MAX_W-1:0] y_ext;

    always_comb begin
        x_ext = '0;
        if (op == OP_AND || op == OP_NAND) x_ext = '1;
        x_ext[WIDTH-1:0] = x;
        y_ext = '0;
        y_ext[WIDTH-1:0] = y;
        res = WIDTH'(apply_op(op, x_ext, y_ext));
        red = reduce_op(op, x_ext);
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Registered logic unit: bitwise, reduce and multi-beat fold modes behind
// valid/ready handshakes; a beat moves when valid && ready at a rising edge.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] count,
    output logic             err,
    output fsm_e             state
);

    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] beats;
    op_e              fold_op;
    op_e              core_op;
    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_res;
    logic             core_red;
    logic [CNT_W-1:0] beats_next;
    logic             at_max;
    logic             accept;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign beats_next = beats + CNT_W'(1);
    assign at_max     = (beats_next == CNT_W'(MAX_BEATS));

    // Continuation beats combine the accumulator with b under the latched op.
    assign core_op = (state == ST_FOLD) ? fold_op : op_e'(op);
    assign core_x  = (state == ST_FOLD) ? acc : a;

    logic_op_core #(.WIDTH(WIDTH)) u_core (
        .op  (core_op),
        .x   (core_x),
        .y   (b),
        .res (core_res),
        .red (core_red)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            beats     <= '0;
            fold_op   <= OP_AND;
            out_valid <= 1'b0;
            y         <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                if (state == ST_IDLE) begin
                    case (mode_e'(mode))
                        MODE_BITWISE: begin
                            out_valid <= 1'b1;
                            y         <= core_res;
                            count     <= CNT_W'(1);
                            err       <= 1'b0;
                        end
                        MODE_REDUCE: begin
                            out_valid <= 1'b1;
                            y         <= {{(WIDTH-1){1'b0}}, core_red};
                            count     <= CNT_W'(1);
                            err       <= 1'b0;
                        end
                        MODE_FOLD: begin
                            if (last) begin
                                out_valid <= 1'b1;
                                y         <= core_res;
                                count     <= CNT_W'(1);
                                err       <= 1'b0;
                            end else begin
                                acc     <= core_res;
                                beats   <= CNT_W'(1);
                                fold_op <= op_e'(op);
                                state   <= ST_FOLD;
                            end
                        end
                        default: begin
                            out_valid <= 1'b1;
                            y         <= '0;
                            count     <= CNT_W'(1);
                            err       <= 1'b1;
                        end
                    endcase
                end else if (last || at_max) begin
                    out_valid <= 1'b1;
                    y         <= core_res;
                    count     <= beats_next;
                    err       <= at_max && !last;
                    acc       <= '0;
                    beats     <= '0;
                    state     <= ST_IDLE;
                end else begin
                    acc   <= core_res;
                    beats <= beats_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: truth-table reference model, per-cycle compare, directed and random beats.
module tb_logic_unit_seq;
    import logic_unit_pkg::*;

    localparam int W  = 8;
    localparam int MB = 4;
    localparam int CW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = '0;
    logic [1:0]    mode = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  y;
    logic [CW-1:0] count;
    logic          err;
    fsm_e          state;

    logic_unit_seq #(.WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .mode(mode), .a(a), .b(b), .last(last),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .count(count), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rand_bp = 1'b0;
    logic [W+CW:0] exp_q[$];

    // Truth table per op, indexed by {x,y}.
    logic [3:0] tt [8];
    bit         m_fold = 1'b0;
    logic [2:0] m_op;
    logic [W-1:0] m_acc;
    int         m_n;

    function automatic logic gate_bit(input logic [2:0] o, input logic xb, input logic yb);
        logic [3:0] row;
        row = tt[o];
        return row[{xb, yb}];
    endfunction

    function automatic logic [W-1:0] gate_vec(input logic [2:0] o, input logic [W-1:0] xv,
                                              input logic [W-1:0] yv);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = gate_bit(o, xv[i], yv[i]);
        return r;
    endfunction

    function automatic logic red_bit(input logic [2:0] o, input logic [W-1:0] xv);
        logic [2:0] base;
        logic       r;
        if (o == 3'd6) return ~xv[0];
        if (o == 3'd7) return xv[0];
        base = (o == 3'd0 || o == 3'd3) ? 3'd0 : (o == 3'd4 || o == 3'd5) ? 3'd4 : 3'd1;
        r = xv[0];
        for (int i = 1; i < W; i++) r = gate_bit(base, r, xv[i]);
        return (o == 3'd2 || o == 3'd3 || o == 3'd5) ? ~r : r;
    endfunction

    task automatic model_beat(input logic [2:0] o, input logic [1:0] m, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic l);
        if (!m_fold) begin
            if (m == 2'd0) exp_q.push_back({gate_vec(o, av, bv), CW'(1), 1'b0});
            else if (m == 2'd1) exp_q.push_back({W'(red_bit(o, av)), CW'(1), 1'b0});
            else if (m == 2'd3) exp_q.push_back({W'(0), CW'(1), 1'b1});
            else begin
                m_acc = gate_vec(o, av, bv);
                m_n   = 1;
                m_op  = o;
                if (l) exp_q.push_back({m_acc, CW'(1), 1'b0});
                else m_fold = 1'b1;
            end
        end else begin
            m_acc = gate_vec(m_op, m_acc, bv);
            m_n++;
            if (l || m_n == MB) begin
                exp_q.push_back({m_acc, CW'(m_n), !l});
                m_fold = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_fold = 1'b0;
        end else begin
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready_rule: got %b want %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got y=%h count=%0d err=%b, none expected", y, count, err);
                end else begin
                    if ({y, count, err} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL model_compare: got y=%h count=%0d err=%b want y=%h count=%0d err=%b",
                                 y, count, err, exp_q[0][W+CW:CW+1], exp_q[0][CW:1], exp_q[0][0]);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) model_beat(op, mode, a, b, last);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [1:0] m, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic l);
        bit got = 1'b0;
        op = o; mode = m; a = av; b = bv; last = l; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_timeout: in_ready got 0 want 1 within 200 cycles");
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [W-1:0] ey, input logic [CW-1:0] ec,
                              input logic ee);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i != 0 || 1'b1) @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, "_valid"}, 32'(seen), 32'd1);
        if (seen) chk(nm, {19'd0, y, count, err}, {19'd0, ey, ec, ee});
        step();
    endtask

    initial begin
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0001; tt[3] = 4'b0111;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b1100;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_y_count_err", {19'd0, y, count, err}, 32'd0);
        chk("reset_state", 32'(state), 32'(ST_IDLE));
        step();

        send(3'd0, 2'd0, 8'hF0, 8'h3C, 1'b0); expect_out("bit_and", 8'h30, 1, 1'b0);
        send(3'd2, 2'd0, 8'hF0, 8'h3C, 1'b0); expect_out("bit_nor", 8'h03, 1, 1'b0);
        send(3'd5, 2'd0, 8'hF0, 8'h3C, 1'b0); expect_out("bit_xnor", 8'h33, 1, 1'b0);
        send(3'd6, 2'd0, 8'hF0, 8'h3C, 1'b0); expect_out("bit_not", 8'h0F, 1, 1'b0);

        send(3'd4, 2'd1, 8'hA5, 8'h00, 1'b0); expect_out("red_xor", 8'h00, 1, 1'b0);
        send(3'd0, 2'd1, 8'hFF, 8'h00, 1'b0); expect_out("red_and", 8'h01, 1, 1'b0);
        send(3'd3, 2'd1, 8'hFF, 8'h00, 1'b0); expect_out("red_nand", 8'h00, 1, 1'b0);
        send(3'd1, 2'd1, 8'h00, 8'h00, 1'b0); expect_out("red_or", 8'h00, 1, 1'b0);
        send(3'd0, 2'd1, 8'hFE, 8'h00, 1'b0); expect_out("red_and_partial", 8'h00, 1, 1'b0);

        send(3'd4, 2'd2, 8'h0F, 8'hF0, 1'b0);
        send(3'd0, 2'd0, 8'h55, 8'hFF, 1'b0);
        send(3'd0, 2'd0, 8'h55, 8'h01, 1'b1);
        expect_out("fold_xor", 8'h01, 3, 1'b0);

        send(3'd1, 2'd2, 8'h00, 8'h01, 1'b0);
        send(3'd1, 2'd2, 8'h00, 8'h02, 1'b0);
        send(3'd1, 2'd2, 8'h00, 8'h04, 1'b0);
        send(3'd1, 2'd2, 8'h00, 8'h08, 1'b0);
        @(negedge clk);
        chk("ovf_state_idle", 32'(state), 32'(ST_IDLE));
        chk("ovf_result", {19'd0, y, count, err}, {19'd0, 8'h0F, 3'd4, 1'b1});
        step();
        send(3'd0, 2'd2, 8'hFF, 8'h3C, 1'b1); expect_out("fold_after_ovf", 8'h3C, 1, 1'b0);

        out_ready = 1'b0;
        send(3'd0, 2'd0, 8'hF0, 8'h3C, 1'b0);
        op = 3'd4; mode = 2'd0; a = 8'hF0; b = 8'h3C; last = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            chk("bp_held", {23'd0, out_valid, y}, {23'd1, 8'h30});
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_high", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_second", {23'd0, out_valid, y}, {23'd1, 8'hCC});
        step();

        send(3'd1, 2'd2, 8'h00, 8'h01, 1'b0);
        send(3'd1, 2'd2, 8'h00, 8'h02, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midfold_rst_valid", 32'(out_valid), 32'd0);
        chk("midfold_rst_count", 32'(count), 32'd0);
        chk("midfold_rst_state", 32'(state), 32'(ST_IDLE));
        step();
        send(3'd0, 2'd2, 8'hFF, 8'h0F, 1'b1); expect_out("fold_single", 8'h0F, 1, 1'b0);
        send(3'd3, 2'd3, 8'hAB, 8'hCD, 1'b0); expect_out("reserved", 8'h00, 1, 1'b1);

        rand_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                 $urandom_range(0, 3) == 0);
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        send(3'd1, 2'd2, 8'h00, 8'h00, 1'b1);
        repeat (10) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_seq.md
Name: logic_unit_seq

Overview:
Parametrised, registered successor to the team's two-input gate-primitive block. It applies one of eight gate operations (AND, OR, NOR, NAND, XOR, XNOR, NOT, BUF) to WIDTH-bit operands in one of three modes: bitwise, reduction, or multi-beat fold (accumulate). It has valid/ready handshakes on input and output and sits between operand producers and consumers in the datapath test fabric.

Parameters:
WIDTH, 8, operand/result width (>=2)
MAX_BEATS, 16, maximum beats in one fold before forced termination (>=2)
CNT_W, $clog2(MAX_BEATS+1), width of beat counter/output

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
op  in  3  0 AND,1 OR,2 NOR,3 NAND,4 XOR,5 XNOR,6 NOT,7 BUF
mode  in  2  0 bitwise,1 reduce,2 fold,3 reserved
a  in  WIDTH  operand A
b  in  WIDTH  operand B
last  in  1  final beat of fold (ignored outside fold)
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
y  out  WIDTH  result
count  out  CNT_W  beats contributing to result
err  out  1  reserved mode or fold overflow

Behaviour:
- Reset: one clock and a synchronous active-high reset; with rst high at a clk edge, out_valid=0, y=0, count=0, err=0, FSM=IDLE, accumulator=0. Reset overrides any in-flight beat or fold.
- in_ready = !out_valid || out_ready (combinational). Same-cycle output drain plus input accept allowed: full throughput.
- Output register holds y/count/err stable while out_valid && !out_ready.
- Bitwise (mode 0): y = a op b. Unary ops use a only: NOT gives ~a, BUF gives a. Latency 1: out_valid rises the cycle after the accepting edge; count=1, err=0.
- Reduce (mode 1): y[0] is the reduction of a over all bits: &a, |a, ~|a, ~&a, ^a, ~^a. NOT gives ~a[0], BUF gives a[0]. y[WIDTH-1:1]=0. Latency 1, count=1.
- Reserved (mode 3): beat is accepted; y=0, count=1, err=1, latency 1.
- Fold (mode 2), FSM IDLE/FOLD:
  - IDLE, accepted fold beat: acc = a op b, beat counter=1, op latched. If last=1, emit immediately (single-beat fold). Otherwise go to FOLD.
  - FOLD, accepted beat: acc = acc op b, with a ignored; unary ops give NOT: acc=~acc, BUF: acc held. Counter increments. op and mode of non-first beats are ignored.
  - Emit when last=1 or the counter reaches MAX_BEATS. Output loads y=acc result, count=counter, err=(counter==MAX_BEATS && !last). Return to IDLE.
  - Fold result latency: 1 cycle after the accepting edge of the final beat.
  - No output is produced for intermediate fold beats. in_ready still obeys the rule above, so a stalled prior result blocks fold beats.
- Widths: all operations are bitwise within WIDTH; no carries. count saturates by construction at MAX_BEATS.

Decomposition:
- logic_unit_pkg holds:
  - op_e enum (8 codes above) and mode_e enum
  - function apply_op(op_e, x, y) returning WIDTH bits
  - function reduce_op(op_e, x) returning 1 bit
- One combinational sub-module, logic_op_core, computes the bitwise result and the reduction bit from op/x/y. It is instanced once, with x muxed between a and acc.
- logic_unit_seq holds the FSM, accumulator, counter and output register.

Test Plan:
- Bitwise AND a=8'hF0 b=8'h3C, out_ready=1 -> next cycle out_valid=1, y=8'h30, count=1, err=0. Repeat for NOR -> 8'h03, XNOR -> 8'h33, NOT -> 8'h0F.
- Reduce: XOR a=8'hA5 -> y=8'h00. AND a=8'hFF -> y=8'h01. NAND a=8'hFF -> y=8'h00. OR a=8'h00 -> y=8'h00.
- Fold XOR beats (a=8'h0F,b=8'hF0), (b=8'hFF), (b=8'h01,last=1) -> single output y=8'h01, count=3, err=0; out_valid is never asserted for beats 1-2.
- Overflow: MAX_BEATS=4, four fold OR beats b=8'h01,02,04,08 with last=0 -> y=8'h0F, count=4, err=1, FSM back to IDLE. The next beat starts a new fold.
- Backpressure: out_ready=0, two back-to-back bitwise beats -> first result held stable, in_ready=0, second beat stalled. Raise out_ready -> first drains and second is accepted the same cycle; second appears next cycle.
- Reset mid-fold after 2 beats, plus reserved mode 3 -> after rst: out_valid=0, count=0. A fresh single-beat fold AND a=8'hFF b=8'h0F last=1 gives y=8'h0F, count=1. Mode 3 gives y=0, err=1.
